cnt_sched: RTL and testbench

CNT_SCHED -- requirements
Module: cnt_sched

---
 rtl/cnt_sched_pkg.sv | 18 +
 rtl/cnt_sched.sv | 112 +++++++++++
 tb/tb_cnt_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cnt_sched_pkg.sv
// rtl/cnt_sched_pkg.sv - opcode and state encodings for the cnt sequencing controller
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_SEEK = 2'b11
  } cnt_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } cnt_state_e;

endpackage

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - command-driven controller sequencing an external cnt (load/step/seek/abort)
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_din,
  input  logic [WIDTH-1:0] cnt_q
);

  cnt_state_e       state_q, state_d;
  cnt_op_e          op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             ready_q, ready_d;
  logic             aborted_q, aborted_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      arg_q     <= '0;
      step_q    <= '0;
      ready_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      step_q    <= step_d;
      ready_q   <= ready_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    step_d    = step_q;
    aborted_d = aborted_q;
    cnt_en    = 1'b0;
    cnt_up    = 1'b0;
    cnt_load  = 1'b0;
    cnt_din   = '0;

    unique case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        if (cmd_valid && ready_q) begin
          op_d    = cnt_op_e'(cmd_op);
          arg_d   = cmd_arg;
          step_d  = cmd_arg;
          state_d = (cnt_op_e'(cmd_op) == OP_LOAD) ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        cnt_din  = arg_q;
        state_d  = ST_DONE;
      end
      ST_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (op_q == OP_SEEK) begin
          // Stop on the cycle the target is observed so the counter never overshoots.
          if (cnt_q == arg_q) begin
            state_d = ST_DONE;
          end else begin
            cnt_en = 1'b1;
            cnt_up = (arg_q > cnt_q);
          end
        end else begin
          cnt_up = (op_q == OP_UP);
          if (step_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_en = 1'b1;
            step_d = step_q - WIDTH'(1);
            if (step_q == WIDTH'(1)) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered so it first rises on the edge after reset release.
  assign ready_d   = (state_d == ST_IDLE);
  assign cmd_ready = ready_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign aborted   = (state_q == ST_DONE) && aborted_q;

endmodule

// File: tb/tb_cnt_sched.sv
// tb/tb_cnt_sched.sv - directed self-checking bench pairing cnt_sched with a behavioural cnt
module tb_cnt_sched;
  import cnt_sched_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_arg = '0;
  logic             abort = 1'b0;
  logic             busy, done, aborted;
  logic             cnt_en, cnt_up, cnt_load;
  logic [WIDTH-1:0] cnt_din;
  logic [WIDTH-1:0] cnt_q;

  int checks = 0;
  int failures = 0;
  int excl_viol = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_load)    cnt_q <= cnt_din;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end

  always @(negedge clk) if (cmd_ready && busy) excl_viol++;

  cnt_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .busy(busy),
    .done(done), .aborted(aborted), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .cnt_load(cnt_load), .cnt_din(cnt_din), .cnt_q(cnt_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    chk("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Counts enabled and busy cycles until done appears, bounded by a cycle budget.
  task automatic run_to_done(output int en_n, output int up_n, output int busy_n, output bit ok);
    en_n = 0; up_n = 0; busy_n = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (cnt_en) en_n++;
      if (cnt_en && cnt_up) up_n++;
      if (busy) busy_n++;
      step();
    end
  endtask

  int  en_n, up_n, busy_n;
  bit  ok;
  bit  saw_done;

  initial begin
    // Reset held for 4 cycles, all outputs low throughout.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_outs", {24'd0, cmd_ready, busy, done, aborted, cnt_en, cnt_up, cnt_load, 1'b0}, 32'd0);
      chk("rst_din", {28'd0, cnt_din}, 32'd0);
    end
    rst = 1'b1;
    chk("ready_at_release", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

    // LOAD 9
    issue(OP_LOAD, 4'd9);
    chk("load_pulse", {31'd0, cnt_load}, 32'd1);
    chk("load_din", {28'd0, cnt_din}, 32'd9);
    chk("load_busy_noready", {30'd0, busy, cmd_ready}, 32'd2);
    step();
    chk("load_done", {29'd0, done, aborted, cnt_load}, 32'd4);
    chk("load_cnt", {28'd0, cnt_q}, 32'd9);
    chk("load_din_idle", {28'd0, cnt_din}, 32'd0);
    step();
    chk("load_ready_back", {30'd0, cmd_ready, done}, 32'd2);

    // LOAD 14, then UP 5 wraps to 3
    issue(OP_LOAD, 4'd14);
    step();
    step();
    issue(OP_UP, 4'd5);
    run_to_done(en_n, up_n, busy_n, ok);
    chk("up5_done_seen", {31'd0, ok}, 32'd1);
    chk("up5_en_cycles", en_n, 32'd5);
    chk("up5_up_cycles", up_n, 32'd5);
    chk("up5_cnt_wrap", {28'd0, cnt_q}, 32'd3);
    chk("up5_aborted", {31'd0, aborted}, 32'd0);
    step();

    // DOWN 0: one RUN cycle with no enable
    issue(OP_DOWN, 4'd0);
    run_to_done(en_n, up_n, busy_n, ok);
    chk("down0_done_seen", {31'd0, ok}, 32'd1);
    chk("down0_en_cycles", en_n, 32'd0);
    chk("down0_run_cycles", busy_n, 32'd1);
    chk("down0_cnt", {28'd0, cnt_q}, 32'd3);
    step();

    // SEEK 12 from 3: nine up-steps, then stop on target
    issue(OP_SEEK, 4'd12);
    run_to_done(en_n, up_n, busy_n, ok);
    chk("seek_done_seen", {31'd0, ok}, 32'd1);
    chk("seek_en_cycles", en_n, 32'd9);
    chk("seek_up_cycles", up_n, 32'd9);
    chk("seek_cnt", {28'd0, cnt_q}, 32'd12);
    step();

    // SEEK 12 again: already on target
    issue(OP_SEEK, 4'd12);
    chk("seek0_run_noen", {30'd0, busy, cnt_en}, 32'd2);
    step();
    chk("seek0_done_next", {31'd0, done}, 32'd1);
    chk("seek0_cnt", {28'd0, cnt_q}, 32'd12);
    step();

    // DOWN 10 from 8, abort on 3rd RUN cycle
    issue(OP_LOAD, 4'd8);
    step();
    step();
    issue(OP_DOWN, 4'd10);
    chk("abort_run1_en", {30'd0, cnt_en, cnt_up}, 32'd2);
    step();
    step();
    abort = 1'b1;
    #1;
    chk("abort_en_drop", {31'd0, cnt_en}, 32'd0);
    step();
    abort = 1'b0;
    chk("abort_done", {30'd0, done, aborted}, 32'd3);
    chk("abort_cnt", {28'd0, cnt_q}, 32'd6);
    step();
    chk("abort_idle", {29'd0, cmd_ready, done, aborted}, 32'd4);

    // Abort outside RUN is ignored by a following LOAD
    abort = 1'b1;
    issue(OP_LOAD, 4'd1);
    chk("abort_in_load", {31'd0, cnt_load}, 32'd1);
    step();
    chk("abort_in_load_done", {30'd0, done, aborted}, 32'd2);
    abort = 1'b0;
    step();

    // Reset in the middle of UP 7
    issue(OP_UP, 4'd7);
    step();
    step();
    chk("rst_mid_running", {31'd0, cnt_en}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", {28'd0, cnt_en, busy, done, cmd_ready}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    chk("rst_mid_ready_low", {31'd0, cmd_ready}, 32'd0);
    step();
    if (done) saw_done = 1'b1;
    chk("rst_mid_no_done", {31'd0, saw_done}, 32'd0);
    chk("rst_mid_ready_back", {30'd0, cmd_ready, busy}, 32'd2);

    chk("ready_busy_exclusive", excl_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
